// File: rtl/bit_manipulation_unit.sv
// Registered 32-bit integer/bit-manipulation execute unit driven by a one-hot predecode vector.
// Define BMU_ZBA_EN to implement sh1add/sh2add/sh3add; otherwise those decodes are illegal.
module bit_manipulation_unit (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        scan_mode,
    input  logic        valid_in,
    input  logic [31:0] ap,
    input  logic        csr_ren_in,
    input  logic [31:0] csr_rddata_in,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic [31:0] result_ff,
    output logic        error
);

    // Everything except csr_imm (1), unsign (13) and zbb (31) is an op bit.
    localparam logic [31:0] OP_MASK = 32'h7FFF_DFFD;

    logic        unused_scan;
    logic [31:0] ops;
    logic        one_hot;
    logic        legal;
    logic [4:0]  shamt;
    logic [31:0] b_eff;
    logic        lt;
    logic [5:0]  clz_cnt;
    logic [5:0]  ctz_cnt;
    logic [5:0]  pop_cnt;
    logic [31:0] res;

    assign unused_scan = scan_mode;

    assign ops     = ap & OP_MASK;
    assign one_hot = (ops != '0) && ((ops & (ops - 32'd1)) == '0);
    assign shamt   = b_in[4:0];
    assign b_eff   = ap[31] ? ~b_in : b_in;
    assign lt      = ap[13] ? (a_in < b_in) : ($signed(a_in) < $signed(b_in));

`ifdef BMU_ZBA_EN
    assign legal = csr_ren_in ? (ops == '0) : one_hot;
`else
    assign legal = csr_ren_in ? (ops == '0) : (one_hot && (ap[30:28] == 3'b000));
`endif

    // Later matches overwrite earlier ones, giving highest/lowest set bit respectively.
    always_comb begin
        clz_cnt = 6'd32;
        ctz_cnt = 6'd32;
        pop_cnt = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (a_in[i])      clz_cnt = 6'(31 - i);
            if (a_in[31 - i]) ctz_cnt = 6'(31 - i);
            pop_cnt = pop_cnt + {5'b0, a_in[i]};
        end
    end

    always_comb begin
        res = '0;
        if (csr_ren_in)  res = csr_rddata_in;
        else if (ap[0])  res = ap[1] ? b_in : a_in;
        else if (ap[2])  res = a_in & b_eff;
        else if (ap[3])  res = a_in | b_eff;
        else if (ap[4])  res = a_in ^ b_eff;
        else if (ap[5])  res = a_in << shamt;
        else if (ap[6])  res = a_in >> shamt;
        else if (ap[7])  res = 32'($signed(a_in) >>> shamt);
        else if (ap[8])  res = (a_in >> shamt) | (a_in << (6'd32 - {1'b0, shamt}));
        else if (ap[9])  res = (a_in << shamt) | (a_in >> (6'd32 - {1'b0, shamt}));
        else if (ap[10]) res = a_in + b_in;
        else if (ap[11]) res = a_in - b_in;
        else if (ap[12]) res = {31'b0, lt};
        else if (ap[14]) res = {26'b0, clz_cnt};
        else if (ap[15]) res = {26'b0, ctz_cnt};
        else if (ap[16]) res = {26'b0, pop_cnt};
        else if (ap[17]) res = {{24{a_in[7]}}, a_in[7:0]};
        else if (ap[18]) res = {{16{a_in[15]}}, a_in[15:0]};
        else if (ap[19]) res = lt ? a_in : b_in;
        else if (ap[20]) res = lt ? b_in : a_in;
        else if (ap[21]) res = {b_in[15:0], a_in[15:0]};
        else if (ap[22]) res = {b_in[31:16], a_in[31:16]};
        else if (ap[23]) res = {16'b0, b_in[7:0], a_in[7:0]};
        else if (ap[24]) res = a_in | (32'd1 << shamt);
        else if (ap[25]) res = a_in & ~(32'd1 << shamt);
        else if (ap[26]) res = a_in ^ (32'd1 << shamt);
        else if (ap[27]) res = {31'b0, a_in[shamt]};
`ifdef BMU_ZBA_EN
        else if (ap[28]) res = {a_in[30:0], 1'b0} + b_in;
        else if (ap[29]) res = {a_in[29:0], 2'b0} + b_in;
        else if (ap[30]) res = {a_in[28:0], 3'b0} + b_in;
`endif
        if (!legal) res = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            result_ff <= '0;
            error     <= 1'b0;
        end else if (valid_in) begin
            result_ff <= res;
            error     <= !legal;
        end else begin
            error     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bit_manipulation_unit.sv
// Directed-vector self-checking bench for bit_manipulation_unit.
module tb_bit_manipulation_unit;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        scan_mode;
    logic        valid_in;
    logic [31:0] ap;
    logic        csr_ren_in;
    logic [31:0] csr_rddata_in;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] result_ff;
    logic        error;

    int total = 0;
    int bad   = 0;

    localparam int CSR_WRITE = 0,  CSR_IMM = 1,  LAND = 2,  LOR = 3,  LXOR = 4;
    localparam int SLL = 5,  SRL = 6,  SRA = 7,  ROR = 8,  ROL = 9,  ADD = 10, SUB = 11;
    localparam int SLT = 12, UNSIGN = 13, CLZ = 14, CTZ = 15, CPOP = 16, SEXT_B = 17;
    localparam int SEXT_H = 18, MIN = 19, MAX = 20, PACK = 21, PACKU = 22, PACKH = 23;
    localparam int BSET = 24, BCLR = 25, BINV = 26, BEXT = 27, SH1ADD = 28, SH3ADD = 30, ZBB = 31;

    bit_manipulation_unit dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .scan_mode    (scan_mode),
        .valid_in     (valid_in),
        .ap           (ap),
        .csr_ren_in   (csr_ren_in),
        .csr_rddata_in(csr_rddata_in),
        .a_in         (a_in),
        .b_in         (b_in),
        .result_ff    (result_ff),
        .error        (error)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bv(input int n);
        return 32'd1 << n;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one op for a single edge, then check result and error after it.
    task automatic run_op(input string tag, input logic [31:0] ap_v, input logic csr_v,
                          input logic [31:0] csr_d, input logic [31:0] a_v, input logic [31:0] b_v,
                          input logic [31:0] exp_res, input logic exp_err);
        valid_in      = 1'b1;
        ap            = ap_v;
        csr_ren_in    = csr_v;
        csr_rddata_in = csr_d;
        a_in          = a_v;
        b_in          = b_v;
        @(posedge clk); #1;
        check({tag, ".res"}, result_ff, exp_res);
        check({tag, ".err"}, {31'b0, error}, {31'b0, exp_err});
    endtask

    task automatic op(input string tag, input logic [31:0] ap_v, input logic [31:0] a_v,
                      input logic [31:0] b_v, input logic [31:0] exp_res);
        run_op(tag, ap_v, 1'b0, '0, a_v, b_v, exp_res, 1'b0);
    endtask

    initial begin
        scan_mode     = 1'b0;
        rst_l         = 1'b0;
        valid_in      = 1'b1;
        ap            = bv(ADD);
        csr_ren_in    = 1'b0;
        csr_rddata_in = '0;
        a_in          = 32'h0000_0005;
        b_in          = 32'h0000_0007;

        // Valid add held during reset must be discarded.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("reset.res", result_ff, '0);
            check("reset.err", {31'b0, error}, '0);
        end
        rst_l    = 1'b1;
        valid_in = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            check("idle.res", result_ff, '0);
            check("idle.err", {31'b0, error}, '0);
        end

        op("add_wrap",  bv(ADD), 32'hFFFF_FFFF, 32'h1, 32'h0);
        op("sub_wrap",  bv(SUB), 32'h0, 32'h1, 32'hFFFF_FFFF);
        op("slt_s",     bv(SLT), 32'h8000_0000, 32'h1, 32'h1);
        op("slt_u",     bv(SLT) | bv(UNSIGN), 32'h8000_0000, 32'h1, 32'h0);
        op("max_s",     bv(MAX), 32'hFFFF_FFFF, 32'h5, 32'h5);
        op("max_u",     bv(MAX) | bv(UNSIGN), 32'hFFFF_FFFF, 32'h5, 32'hFFFF_FFFF);
        op("min_s",     bv(MIN), 32'hFFFF_FFFF, 32'h5, 32'hFFFF_FFFF);
        op("min_u",     bv(MIN) | bv(UNSIGN), 32'hFFFF_FFFF, 32'h5, 32'h5);
        op("clz_zero",  bv(CLZ), 32'h0, 32'h0, 32'd32);
        op("clz",       bv(CLZ), 32'h0001_0000, 32'h0, 32'd15);
        op("ctz",       bv(CTZ), 32'h0000_0100, 32'h0, 32'd8);
        op("ctz_zero",  bv(CTZ), 32'h0, 32'h0, 32'd32);
        op("cpop",      bv(CPOP), 32'hF0F0_0001, 32'h0, 32'd9);
        op("cpop_all",  bv(CPOP), 32'hFFFF_FFFF, 32'h0, 32'd32);
        op("ror1",      bv(ROR), 32'h0000_0001, 32'h1, 32'h8000_0000);
        op("ror0",      bv(ROR), 32'h1234_5678, 32'h20, 32'h1234_5678);
        op("rol1",      bv(ROL), 32'h8000_0001, 32'h1, 32'h0000_0003);
        op("rol0",      bv(ROL), 32'hCAFE_BABE, 32'h0, 32'hCAFE_BABE);
        op("sll31",     bv(SLL), 32'h0000_0001, 32'h1F, 32'h8000_0000);
        op("sll_mask",  bv(SLL), 32'h0000_0001, 32'h21, 32'h0000_0002);
        op("srl",       bv(SRL), 32'h8000_0000, 32'h4, 32'h0800_0000);
        op("sra",       bv(SRA), 32'h8000_0000, 32'h4, 32'hF800_0000);
        op("and",       bv(LAND), 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        op("andn",      bv(LAND) | bv(ZBB), 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h00F0_00F0);
        op("or",        bv(LOR), 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
        op("orn",       bv(LOR) | bv(ZBB), 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF0FF_F0FF);
        op("xor",       bv(LXOR), 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
        op("xnor",      bv(LXOR) | bv(ZBB), 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF00F_F00F);
        op("sext_b",    bv(SEXT_B), 32'h0000_0080, 32'h0, 32'hFFFF_FF80);
        op("sext_h",    bv(SEXT_H), 32'h1234_7FFF, 32'h0, 32'h0000_7FFF);
        op("pack",      bv(PACK), 32'h1111_2222, 32'h3333_4444, 32'h4444_2222);
        op("packu",     bv(PACKU), 32'h1111_2222, 32'h3333_4444, 32'h3333_1111);
        op("packh",     bv(PACKH), 32'h1111_2222, 32'h3333_4444, 32'h0000_4422);
        op("bset",      bv(BSET), 32'h0, 32'h1F, 32'h8000_0000);
        op("bclr",      bv(BCLR), 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFE);
        op("binv",      bv(BINV), 32'h0000_000F, 32'h3, 32'h0000_0007);
        op("bext1",     bv(BEXT), 32'h0000_0010, 32'h4, 32'h1);
        op("bext0",     bv(BEXT), 32'h0000_0010, 32'h5, 32'h0);
        op("csrw",      bv(CSR_WRITE), 32'h5, 32'h7, 32'h5);
        op("csrwi",     bv(CSR_WRITE) | bv(CSR_IMM), 32'h5, 32'h7, 32'h7);
`ifdef BMU_ZBA_EN
        op("sh1add",    bv(SH1ADD), 32'h3, 32'h1, 32'h7);
        op("sh3add",    bv(SH3ADD), 32'h2000_0001, 32'h2, 32'h0000_000A);
`else
        run_op("sh1add_off", bv(SH1ADD), 1'b0, '0, 32'h3, 32'h1, 32'h0, 1'b1);
        run_op("sh3add_off", bv(SH3ADD), 1'b0, '0, 32'h2000_0001, 32'h2, 32'h0, 1'b1);
`endif

        run_op("csr_rd",     32'h0, 1'b1, 32'h1234_5678, 32'h0, 32'h0, 32'h1234_5678, 1'b0);
        run_op("csr_rd_mod", bv(UNSIGN) | bv(ZBB), 1'b1, 32'hA5A5_0000, 32'h1, 32'h1,
               32'hA5A5_0000, 1'b0);
        run_op("csr_rd_add", bv(ADD), 1'b1, 32'h1234_5678, 32'h1, 32'h1, 32'h0, 1'b1);
        run_op("no_op",      32'h0, 1'b0, '0, 32'h1, 32'h1, 32'h0, 1'b1);
        run_op("zbb_only",   bv(ZBB), 1'b0, '0, 32'h1, 32'h1, 32'h0, 1'b1);
        run_op("two_ops",    bv(ADD) | bv(SUB), 1'b0, '0, 32'h9, 32'h1, 32'h0, 1'b1);
        run_op("land_lor",   bv(LAND) | bv(LOR), 1'b0, '0, 32'hFF, 32'hF0, 32'h0, 1'b1);

        // Idle cycle after an error: error clears, result holds 0.
        valid_in = 1'b0;
        ap       = bv(ADD);
        @(posedge clk); #1;
        check("idle_err.res", result_ff, 32'h0);
        check("idle_err.err", {31'b0, error}, 32'h0);

        // Hold a nonzero result across idle cycles while inputs change.
        op("hold_set", bv(ADD), 32'h1000_0000, 32'h0000_0234, 32'h1000_0234);
        valid_in = 1'b0;
        ap       = bv(SUB);
        a_in     = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("hold.res", result_ff, 32'h1000_0234);
            check("hold.err", {31'b0, error}, 32'h0);
        end

        // Reset overrides a simultaneous valid op.
        rst_l = 1'b0;
        valid_in = 1'b1;
        ap = bv(ADD);
        a_in = 32'h1;
        b_in = 32'h1;
        @(posedge clk); #1;
        check("rst_ovr.res", result_ff, 32'h0);
        check("rst_ovr.err", {31'b0, error}, 32'h0);
        rst_l = 1'b1;
        op("post_rst", bv(ADD), 32'h1, 32'h1, 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
